aes_stream_framer: RTL and testbench

AES_STREAM_FRAMER -- requirements
Module: aes_stream_framer

---
 rtl/aes_stream_framer.sv | 157 +++++++++++++++
 tb/tb_aes_stream_framer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_framer.sv
// rtl/aes_stream_framer.sv - byte-stream framer feeding a block cipher and serialising its result
module aes_stream_framer #(
   parameter int Nk  = 4,
   parameter int LAT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_byte,
   input  logic              reuse_key,
   output logic [Nk*32-1:0]  key_out,
   output logic [127:0]      data_out,
   input  logic [127:0]      cipher_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_byte,
   output logic              busy
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_KEY  = 3'd1;
   localparam logic [2:0] ST_DATA = 3'd2;
   localparam logic [2:0] ST_WAIT = 3'd3;
   localparam logic [2:0] ST_SEND = 3'd4;

   localparam int         KEY_W    = Nk * 32;
   // Key byte 0 is taken in IDLE, so the last key byte arrives when KEY has counted Nk*4-2 bytes.
   localparam logic [4:0] KEY_LAST = 5'(Nk * 4 - 2);
   localparam logic [3:0] LAT_LOAD = 4'(LAT);

   logic [2:0]       state_q, state_d;
   logic [4:0]       cnt_q, cnt_d;
   logic [3:0]       wait_q, wait_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [127:0]     data_q, data_d;
   logic [127:0]     sh_q, sh_d;
   logic             key_loaded_q, key_loaded_d;
   // Set when data byte 0 was consumed in IDLE (reused key), which moves the DATA end count down by one.
   logic             data_pre_q, data_pre_d;

   logic             in_acc;
   logic             out_acc;
   logic [4:0]       data_last;

   assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_KEY) || (state_q == ST_DATA);
   assign out_valid = (state_q == ST_SEND);
   assign busy      = (state_q != ST_IDLE);
   assign out_byte  = sh_q[127:120];
   assign key_out   = key_q;
   assign data_out  = data_q;

   assign in_acc    = in_valid && in_ready;
   assign out_acc   = out_valid && out_ready;
   assign data_last = data_pre_q ? 5'd14 : 5'd15;

   // Next-state logic: byte assembly, cipher wait and output serialisation.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wait_d       = wait_q;
      key_d        = key_q;
      data_d       = data_q;
      sh_d         = sh_q;
      key_loaded_d = key_loaded_q;
      data_pre_d   = data_pre_q;

      case (state_q)
         ST_IDLE: begin
            if (in_acc) begin
               cnt_d = 5'd0;
               if (reuse_key && key_loaded_q) begin
                  data_d     = {data_q[119:0], in_byte};
                  data_pre_d = 1'b1;
                  state_d    = ST_DATA;
               end else begin
                  key_d        = {key_q[KEY_W-9:0], in_byte};
                  key_loaded_d = 1'b0;
                  state_d      = ST_KEY;
               end
            end
         end
         ST_KEY: begin
            if (in_acc) begin
               key_d = {key_q[KEY_W-9:0], in_byte};
               if (cnt_q == KEY_LAST) begin
                  key_loaded_d = 1'b1;
                  data_pre_d   = 1'b0;
                  cnt_d        = 5'd0;
                  state_d      = ST_DATA;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (in_acc) begin
               data_d = {data_q[119:0], in_byte};
               if (cnt_q == data_last) begin
                  wait_d  = LAT_LOAD;
                  cnt_d   = 5'd0;
                  state_d = ST_WAIT;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         ST_WAIT: begin
            if (wait_q == 4'd0) begin
               sh_d    = cipher_result;
               state_d = ST_SEND;
            end else begin
               wait_d = wait_q - 4'd1;
            end
         end
         ST_SEND: begin
            if (out_acc) begin
               sh_d = {sh_q[119:0], 8'h00};
               if (cnt_q == 5'd15) begin
                  cnt_d   = 5'd0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         default: begin
            cnt_d   = 5'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset discards any partial frame and forgets the loaded key.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 5'd0;
         wait_q       <= 4'd0;
         key_q        <= '0;
         data_q       <= '0;
         sh_q         <= '0;
         key_loaded_q <= 1'b0;
         data_pre_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wait_q       <= wait_d;
         key_q        <= key_d;
         data_q       <= data_d;
         sh_q         <= sh_d;
         key_loaded_q <= key_loaded_d;
         data_pre_q   <= data_pre_d;
      end
   end

endmodule

// File: tb/tb_aes_stream_framer.sv
// tb/tb_aes_stream_framer.sv - directed bench for aes_stream_framer with LAT=0 and LAT=5 instances
module tb_aes_stream_framer;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, reuse_key, out_ready, sel;
   logic [7:0] in_byte;

   logic         ir0, ov0, bz0, ir5, ov5, bz5;
   logic [7:0]   ob0, ob5;
   logic [127:0] ko0, do0, cr0, ko5, do5, cr5;

   logic         in_ready_m, out_valid_m, busy_m;
   logic [7:0]   out_byte_m;
   logic [127:0] key_m, data_m;

   int errors = 0;
   int checks = 0;
   int xfers;
   int key_bad;
   logic watch_key = 1'b0;

   // Known-answer cipher: the two FIPS-197 AES-128 vectors, anything else yields a poison value.
   function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
      if (k == K1 && p == P1) return C1;
      if (k == K2 && p == P2) return C2;
      return 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
   endfunction

   assign cr0 = aes_ref(ko0, do0);
   assign cr5 = aes_ref(ko5, do5);

   aes_stream_framer #(.Nk(4), .LAT(0)) u_lat0 (
      .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(ir0), .in_byte(in_byte),
      .reuse_key(reuse_key), .key_out(ko0), .data_out(do0), .cipher_result(cr0),
      .out_valid(ov0), .out_ready(out_ready & ~sel), .out_byte(ob0), .busy(bz0)
   );

   aes_stream_framer #(.Nk(4), .LAT(5)) u_lat5 (
      .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(ir5), .in_byte(in_byte),
      .reuse_key(reuse_key), .key_out(ko5), .data_out(do5), .cipher_result(cr5),
      .out_valid(ov5), .out_ready(out_ready & sel), .out_byte(ob5), .busy(bz5)
   );

   assign in_ready_m  = sel ? ir5 : ir0;
   assign out_valid_m = sel ? ov5 : ov0;
   assign busy_m      = sel ? bz5 : bz0;
   assign out_byte_m  = sel ? ob5 : ob0;
   assign key_m       = sel ? ko5 : ko0;
   assign data_m      = sel ? do5 : do0;

   always @(posedge clk) begin
      if (rst) xfers <= 0;
      else if (in_valid && in_ready_m) xfers <= xfers + 1;
   end

   always @(negedge clk) begin
      if (watch_key && key_m !== K1) key_bad <= key_bad + 1;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rk);
      int n;
      n = 0;
      in_valid = 1'b1; in_byte = b; reuse_key = rk;
      while (!in_ready_m && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) chk("in_timeout", 1, 0);
      @(negedge clk);
      in_valid = 1'b0; reuse_key = 1'b0;
   endtask

   task automatic send_bytes(input logic [127:0] v, input logic rk_first);
      for (int i = 0; i < 16; i++) send_byte(v[127-8*i -: 8], (i == 0) ? rk_first : 1'b0);
   endtask

   task automatic send_frame(input logic with_key, input logic rk, input logic [127:0] k, input logic [127:0] p);
      if (with_key) begin
         send_bytes(k, rk);
         send_bytes(p, 1'b0);
      end else begin
         send_bytes(p, rk);
      end
   endtask

   task automatic measure_latency(input string tag, input int exp);
      int n;
      n = 0;
      out_ready = 1'b0;
      while (!out_valid_m && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, n, exp);
   endtask

   task automatic recv(input int nbytes, input logic rnd, output logic [127:0] got, output int holds_bad);
      int cnt, n;
      logic [7:0] hb;
      got = '0; cnt = 0; n = 0; holds_bad = 0;
      while (cnt < nbytes && n < 2000) begin
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid_m && out_ready) begin
            got = {got[119:0], out_byte_m};
            cnt++;
            @(negedge clk);
         end else if (out_valid_m) begin
            hb = out_byte_m;
            @(negedge clk);
            if (!out_valid_m || out_byte_m !== hb) holds_bad++;
         end else begin
            @(negedge clk);
         end
         n++;
      end
      out_ready = 1'b0;
      if (cnt < nbytes) chk("recv_timeout", cnt, nbytes);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] got;
      int hb;
      rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; reuse_key = 1'b0; out_ready = 1'b0; sel = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      chk("rst_in_ready", in_ready_m, 1);
      chk("rst_out_valid", out_valid_m, 0);
      chk("rst_out_byte", out_byte_m, 0);
      chk("rst_busy", busy_m, 0);
      chk("rst_key", key_m, 0);
      chk("rst_data", data_m, 0);

      // Full key frame, LAT=0
      send_frame(1'b1, 1'b0, K1, P1);
      chk("t1_in_blocked", in_ready_m, 0);
      chk("t1_key", key_m, K1);
      chk("t1_data", data_m, P1);
      measure_latency("t1_latency", 1);
      recv(16, 1'b0, got, hb);
      chk("t1_cipher", got, C1);
      chk("t1_data_hold", data_m, P1);
      chk("t1_idle_busy", busy_m, 0);
      chk("t1_idle_ready", in_ready_m, 1);

      // Reused key frame
      key_bad = 0;
      watch_key = 1'b1;
      send_frame(1'b0, 1'b1, K1, P1);
      chk("t2_in_blocked", in_ready_m, 0);
      measure_latency("t2_latency", 1);
      recv(16, 1'b0, got, hb);
      chk("t2_cipher", got, C1);
      watch_key = 1'b0;
      @(negedge clk);
      chk("t2_key_stable", key_bad, 0);

      // reuse_key right after reset is a key frame
      do_reset();
      chk("t3_key_cleared", key_m, 0);
      send_bytes(K1, 1'b1);
      chk("t3_still_ready", in_ready_m, 1);
      chk("t3_key", key_m, K1);
      send_bytes(P1, 1'b0);
      chk("t3_in_blocked", in_ready_m, 0);
      chk("t3_xfers", xfers, 32);
      measure_latency("t3_latency", 1);
      recv(16, 1'b0, got, hb);
      chk("t3_cipher", got, C1);

      // LAT=5 with random backpressure
      sel = 1'b1;
      do_reset();
      send_frame(1'b1, 1'b0, K1, P1);
      measure_latency("t4_latency", 6);
      recv(16, 1'b1, got, hb);
      chk("t4_cipher", got, C1);
      chk("t4_hold", hb, 0);

      // Reset after 7 key bytes, then a clean frame
      sel = 1'b0;
      do_reset();
      for (int i = 0; i < 7; i++) send_byte(K1[127-8*i -: 8], 1'b0);
      chk("t5_mid_busy", busy_m, 1);
      do_reset();
      chk("t5_rst_busy", busy_m, 0);
      send_frame(1'b1, 1'b0, K2, P2);
      chk("t5_key", key_m, K2);
      measure_latency("t5_latency", 1);
      recv(16, 1'b0, got, hb);
      chk("t5_cipher", got, C2);

      // Reset in SEND after 3 bytes
      send_frame(1'b1, 1'b0, K1, P1);
      measure_latency("t6_latency", 1);
      recv(3, 1'b0, got, hb);
      chk("t6_first3", got[23:0], C1[127:104]);
      do_reset();
      chk("t6_out_valid", out_valid_m, 0);
      chk("t6_in_ready", in_ready_m, 1);
      chk("t6_busy", busy_m, 0);
      send_bytes(K2, 1'b1);
      chk("t6_key_frame", in_ready_m, 1);
      chk("t6_key", key_m, K2);
      send_bytes(P2, 1'b0);
      measure_latency("t6_latency2", 1);
      recv(16, 1'b0, got, hb);
      chk("t6_cipher", got, C2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
